// File: rtl/uart.sv
`default_nettype none
// ============================================================================
// Module   : uart
// Purpose  : Full-duplex 8N1 UART between the RX/TX pins and the I/O register
//            block; one shared baud divider, independent TX and RX paths.
// Revision : 1.0 - initial release
// ============================================================================
module uart #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txd_data,
    input  logic       transmit,
    output logic       txd_done,
    output logic       uart_txd,
    input  logic       uart_rxd,
    output logic [7:0] rxd_data,
    output logic       rxd_done,
    output logic       rx_frame_err
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // transmitter
    state_t             tx_state_q, tx_state_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]         tx_bit_q, tx_bit_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic               tx_line_q, tx_line_d;
    logic               tx_idle_q, tx_idle_d;
    logic               transmit_q, transmit_d;

    // receiver
    logic               rx_meta_q, rx_meta_d;
    logic               rx_s_q, rx_s_d;
    state_t             rx_state_q, rx_state_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_done_q, rx_done_d;
    logic               rx_err_q, rx_err_d;
    logic               rx_wait_q, rx_wait_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            tx_idle_q  <= 1'b1;
            transmit_q <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_wait_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            tx_idle_q  <= tx_idle_d;
            transmit_q <= transmit_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
            rx_err_q   <= rx_err_d;
            rx_wait_q  <= rx_wait_d;
        end
    end

    // Edge register tracks transmit in every state so a busy-time edge is lost.
    always_comb begin
        transmit_d = transmit;
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_idle_d  = tx_idle_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (transmit && !transmit_q) begin
                    tx_shift_d = txd_data;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = 1'b0;
                    tx_idle_d  = 1'b0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == c_bit_last) begin
                    tx_cnt_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + c_cnt_one;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == c_bit_last) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + c_cnt_one;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == c_bit_last) begin
                    tx_cnt_d   = '0;
                    tx_idle_d  = 1'b1;
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + c_cnt_one;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // After a bad stop bit, rx_wait holds off start detection until the line is high.
    always_comb begin
        rx_meta_d  = uart_rxd;
        rx_s_d     = rx_meta_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_done_d  = rx_done_q;
        rx_err_d   = rx_err_q;
        rx_wait_d  = rx_wait_q;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_wait_q) begin
                    if (rx_s_q) begin
                        rx_wait_d = 1'b0;
                    end
                end else if (!rx_s_q) begin
                    rx_cnt_d   = '0;
                    rx_done_d  = 1'b0;
                    rx_err_d   = 1'b0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == c_half_last) begin
                    rx_cnt_d = '0;
                    if (rx_s_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_bit_d   = '0;
                        rx_state_d = ST_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + c_cnt_one;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == c_bit_last) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + c_cnt_one;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == c_bit_last) begin
                    rx_cnt_d = '0;
                    if (rx_s_q) begin
                        rx_data_d = rx_shift_q;
                        rx_done_d = 1'b1;
                    end else begin
                        rx_err_d  = 1'b1;
                        rx_wait_d = 1'b1;
                    end
                    rx_state_d = ST_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + c_cnt_one;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    assign uart_txd     = tx_line_q;
    assign txd_done     = tx_idle_q;
    assign rxd_data     = rx_data_q;
    assign rxd_done     = rx_done_q;
    assign rx_frame_err = rx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart
// Purpose  : Directed self-checking bench for uart (DIV=16 unit, DIV=434 loopback).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart;

    logic       clk;
    logic       rst;
    logic [7:0] txd_data;
    logic       transmit;
    logic       txd_done;
    logic       uart_txd;
    logic       rxd_pin;
    logic [7:0] rxd_data;
    logic       rxd_done;
    logic       rx_frame_err;

    logic [7:0] lb_data;
    logic       lb_transmit;
    logic       lb_txd_done;
    logic       lb_line;
    logic [7:0] lb_rxd_data;
    logic       lb_rxd_done;
    logic       lb_err;

    int n_vec = 0;
    int n_bad = 0;

    uart #(.CLK_HZ(16), .BAUD(1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .txd_data     (txd_data),
        .transmit     (transmit),
        .txd_done     (txd_done),
        .uart_txd     (uart_txd),
        .uart_rxd     (rxd_pin),
        .rxd_data     (rxd_data),
        .rxd_done     (rxd_done),
        .rx_frame_err (rx_frame_err)
    );

    uart #(.CLK_HZ(50000000), .BAUD(115200)) u_lb (
        .clk          (clk),
        .rst          (rst),
        .txd_data     (lb_data),
        .transmit     (lb_transmit),
        .txd_done     (lb_txd_done),
        .uart_txd     (lb_line),
        .uart_rxd     (lb_line),
        .rxd_data     (lb_rxd_data),
        .rxd_done     (lb_rxd_done),
        .rx_frame_err (lb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Checks one 160-cycle frame of byte b; the edge on transmit happens at the
    // clock edge following the call. With poke set, a second rising edge of
    // transmit (and new data) lands at N+50 and must not disturb the frame.
    task automatic tx_frame(input logic [7:0] b, input bit poke);
        int k;
        txd_data = b;
        transmit = 1'b1;
        for (int i = 1; i <= 161; i++) begin
            @(negedge clk);
            if (poke && i == 49) transmit = 1'b0;
            if (poke && i == 50) begin
                transmit = 1'b1;
                txd_data = ~b;
            end
            if (i == 1) begin
                check("tx_start_line", 32'(uart_txd), 32'd0);
                check("tx_start_busy", 32'(txd_done), 32'd0);
            end
            if (i == 8) check("tx_start_mid", 32'(uart_txd), 32'd0);
            if (i >= 24 && i <= 136 && (i % 16) == 8) begin
                k = i / 16 - 1;
                check("tx_data_bit", 32'(uart_txd), 32'(b[k]));
            end
            if (i == 152) check("tx_stop_line", 32'(uart_txd), 32'd1);
            if (i == 160) check("tx_busy_last", 32'(txd_done), 32'd0);
            if (i == 161) check("tx_done_n161", 32'(txd_done), 32'd1);
        end
    endtask

    task automatic tx_quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || txd_done !== 1'b1) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    // Bit periods alternate 17/15 cycles (about +/-6% per bit) when skew is set.
    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input bit skew,
                            input bit chk_clear);
        logic v;
        int   d;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 1'b0 : ((i == 9) ? stop_bit : b[i-1]);
            d = skew ? (((i % 2) == 1) ? 15 : 17) : 16;
            rxd_pin = v;
            tick(d);
            if (chk_clear && i == 0) check("rx_done_clr_on_start", 32'(rxd_done), 32'd0);
        end
        rxd_pin = 1'b1;
    endtask

    function automatic logic pick(input int which);
        case (which)
            0:       return lb_txd_done;
            default: return lb_rxd_done;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int which, input logic lvl, input int max_cyc);
        int   n;
        logic v;
        n = 0;
        v = pick(which);
        while (v !== lvl && n < max_cyc) begin
            @(negedge clk);
            n++;
            v = pick(which);
        end
        check(tag, 32'(v), 32'(lvl));
    endtask

    task automatic lb_byte(input logic [7:0] b);
        lb_data     = b;
        lb_transmit = 1'b1;
        wait_sig("lb_rx_done_clear", 1, 1'b0, 20);
        wait_sig("lb_rx_done_set", 1, 1'b1, 12 * 434);
        check("lb_rx_data", 32'(lb_rxd_data), 32'(b));
        check("lb_rx_err", 32'(lb_err), 32'd0);
        wait_sig("lb_tx_done", 0, 1'b1, 2 * 434);
        @(negedge clk);
        lb_transmit = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        txd_data    = 8'h00;
        transmit    = 1'b0;
        rxd_pin     = 1'b1;
        lb_data     = 8'h00;
        lb_transmit = 1'b0;
        tick(3);
        check("rst_uart_txd", 32'(uart_txd), 32'd1);
        check("rst_txd_done", 32'(txd_done), 32'd1);
        check("rst_rxd_data", 32'(rxd_data), 32'h00);
        check("rst_rxd_done", 32'(rxd_done), 32'd0);
        check("rst_frame_err", 32'(rx_frame_err), 32'd0);
        rst = 1'b0;
        tick(3);

        // TX 0xA5, then transmit stays high: exactly one frame
        tx_frame(8'hA5, 1'b0);
        tx_quiet("tx_hold_no_refire", 40);

        // TX busy: extra edge at N+50 ignored; a later toggle sends the next byte
        transmit = 1'b0;
        tick(2);
        tx_frame(8'h5A, 1'b1);
        tx_quiet("tx_busy_edge_dropped", 40);
        transmit = 1'b0;
        tick(1);
        tx_frame(8'hC3, 1'b0);

        // RX 4-cycle glitch is a false start
        rxd_pin = 1'b0;
        tick(4);
        rxd_pin = 1'b1;
        tick(40);
        check("rx_glitch_done", 32'(rxd_done), 32'd0);
        check("rx_glitch_err", 32'(rx_frame_err), 32'd0);
        check("rx_glitch_data", 32'(rxd_data), 32'h00);

        // RX 0x3C with per-bit skew
        rx_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        tick(2);
        check("rx_3c_data", 32'(rxd_data), 32'h3C);
        check("rx_3c_done", 32'(rxd_done), 32'd1);
        check("rx_3c_err", 32'(rx_frame_err), 32'd0);
        tick(40);
        check("rx_done_sticky", 32'(rxd_done), 32'd1);

        // RX 0x81 with a low stop bit
        rx_frame(8'h81, 1'b0, 1'b0, 1'b1);
        tick(4);
        check("rx_ferr_set", 32'(rx_frame_err), 32'd1);
        check("rx_ferr_done", 32'(rxd_done), 32'd0);
        check("rx_ferr_data_kept", 32'(rxd_data), 32'h3C);

        // Asynchronous reset mid-frame on both directions
        transmit = 1'b0;
        tick(2);
        txd_data = 8'h00;
        transmit = 1'b1;
        tick(30);
        rxd_pin = 1'b0;
        tick(10);
        check("pre_rst_line_low", 32'(uart_txd), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_uart_txd", 32'(uart_txd), 32'd1);
        check("mid_rst_txd_done", 32'(txd_done), 32'd1);
        check("mid_rst_rxd_done", 32'(rxd_done), 32'd0);
        check("mid_rst_rxd_data", 32'(rxd_data), 32'h00);
        check("mid_rst_frame_err", 32'(rx_frame_err), 32'd0);
        transmit = 1'b0;
        rxd_pin  = 1'b1;
        tick(2);
        rst = 1'b0;
        tx_quiet("post_rst_no_frame", 40);
        check("post_rst_rx_idle", 32'(rxd_done), 32'd0);
        tx_frame(8'h96, 1'b0);

        // Loopback at DIV=434
        lb_byte(8'h00);
        lb_byte(8'hFF);
        lb_byte(8'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
